// File: rtl/sequential_fifo.sv
// Single-clock FIFO with occupancy count, registered status flags, sticky error
// flags and a choice of registered-read or show-ahead output.
module sequential_fifo #(
    parameter int DATA_WIDTH         = 8,
    parameter int DEPTH              = 16,
    parameter int ALMOST_FULL_LEVEL  = DEPTH - 2,
    parameter int ALMOST_EMPTY_LEVEL = 2,
    parameter int SHOWAHEAD          = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       request_write,
    input  logic                       request_read,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       clear_errors,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(ALMOST_FULL_LEVEL);
    localparam logic [CW-1:0] AE_LVL   = CW'(ALMOST_EMPTY_LEVEL);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, empty_q;
    logic                  almost_full_q, almost_empty_q;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;

    logic                  rd_accept;
    logic                  wr_accept;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign rd_accept = request_read && !empty_q;
    assign wr_accept = request_write && (!full_q || rd_accept);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clear_errors) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        // A fresh error event in the clearing cycle wins over the clear.
        if (request_write && !wr_accept) begin
            overflow_d = 1'b1;
        end
        if (request_read && !rd_accept) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= (count_d == CNT_MAX);
            empty_q        <= (count_d == CNT_ZERO);
            almost_full_q  <= (count_d >= AF_LVL);
            almost_empty_q <= (count_d <= AE_LVL);
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // Storage is never cleared; the pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (wr_accept && !reset) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (SHOWAHEAD == 0) begin : g_registered_read
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_out_q   <= '0;
                    data_valid_q <= 1'b0;
                end else begin
                    data_valid_q <= rd_accept;
                    if (rd_accept) begin
                        data_out_q <= mem[rd_ptr_q];
                    end
                end
            end
        end else begin : g_show_ahead
            logic head_bypass;

            // The next head is the word being written right now when the write
            // lands on the slot the read pointer is about to point at.
            assign head_bypass = wr_accept && (wr_ptr_q == rd_ptr_d);

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_out_q   <= '0;
                    data_valid_q <= 1'b0;
                end else begin
                    data_valid_q <= (count_d != CNT_ZERO);
                    if (count_d != CNT_ZERO) begin
                        data_out_q <= head_bypass ? data_in : mem[rd_ptr_d];
                    end
                end
            end
        end
    endgenerate

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sequential_fifo.sv
// Directed scoreboard bench for sequential_fifo: registered-read instance driven
// against a queue model, plus a short show-ahead instance sequence.
module tb_sequential_fifo;

    logic       clk;
    logic       reset, request_write, request_read, clear_errors;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       sa_reset, sa_write, sa_read, sa_clear;
    logic [7:0] sa_data_in, sa_data_out;
    logic       sa_valid, sa_full, sa_empty, sa_afull, sa_aempty, sa_ovf, sa_udf;
    logic [4:0] sa_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_q [$];
    logic [7:0] m_dout;
    logic       m_dv, m_ovf, m_udf;

    sequential_fifo #(.DATA_WIDTH(8), .DEPTH(16), .SHOWAHEAD(0)) dut (
        .clk(clk), .reset(reset), .request_write(request_write), .request_read(request_read),
        .data_in(data_in), .clear_errors(clear_errors), .data_out(data_out),
        .data_valid(data_valid), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    sequential_fifo #(.DATA_WIDTH(8), .DEPTH(16), .SHOWAHEAD(1)) dut_sa (
        .clk(clk), .reset(sa_reset), .request_write(sa_write), .request_read(sa_read),
        .data_in(sa_data_in), .clear_errors(sa_clear), .data_out(sa_data_out),
        .data_valid(sa_valid), .count(sa_count), .full(sa_full), .empty(sa_empty),
        .almost_full(sa_afull), .almost_empty(sa_aempty),
        .overflow(sa_ovf), .underflow(sa_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on the registered-read instance, model update, then check.
    task automatic step(input logic rst, input logic wr, input logic rd,
                        input logic clr, input logic [7:0] d);
        logic rd_ok, wr_ok;
        reset         = rst;
        request_write = wr;
        request_read  = rd;
        clear_errors  = clr;
        data_in       = d;
        if (rst) begin
            m_q.delete();
            m_dout = 8'h00;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            rd_ok = rd && (m_q.size() != 0);
            wr_ok = wr && ((m_q.size() != 16) || rd_ok);
            m_dv  = rd_ok;
            if (rd_ok) m_dout = m_q.pop_front();
            if (wr_ok) m_q.push_back(d);
            if (clr) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (wr && !wr_ok) m_ovf = 1'b1;
            if (rd && !rd_ok) m_udf = 1'b1;
        end
        @(posedge clk);
        #1;
        $display("txn rst=%0b wr=%0b rd=%0b clr=%0b din=%0d -> dout=%0d dv=%0b count=%0d ovf=%0b udf=%0b",
                 rst, wr, rd, clr, d, data_out, data_valid, count, overflow, underflow);
        chk("data_valid",   32'(data_valid),   32'(m_dv));
        chk("data_out",     32'(data_out),     32'(m_dout));
        chk("count",        32'(count),        32'(m_q.size()));
        chk("full",         32'(full),         32'(m_q.size() == 16));
        chk("empty",        32'(empty),        32'(m_q.size() == 0));
        chk("almost_full",  32'(almost_full),  32'(m_q.size() >= 14));
        chk("almost_empty", 32'(almost_empty), 32'(m_q.size() <= 2));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
    endtask

    task automatic sa_cycle(input logic wr, input logic rd, input logic [7:0] d);
        sa_write   = wr;
        sa_read    = rd;
        sa_data_in = d;
        @(posedge clk);
        #1;
        sa_write = 1'b0;
        sa_read  = 1'b0;
        $display("txn showahead wr=%0b rd=%0b din=%0h -> dout=%0h dv=%0b count=%0d",
                 wr, rd, d, sa_data_out, sa_valid, sa_count);
    endtask

    initial begin
        reset = 1'b1; request_write = 1'b0; request_read = 1'b0;
        clear_errors = 1'b0; data_in = 8'h00;
        sa_reset = 1'b1; sa_write = 1'b0; sa_read = 1'b0; sa_clear = 1'b0; sa_data_in = 8'h00;
        m_dout = 8'h00; m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;

        // 1: reset state, then read on empty
        step(1, 0, 0, 0, 8'd0);
        step(1, 0, 0, 0, 8'd0);
        step(0, 0, 1, 0, 8'd0);

        // 2: fill with 0,3,...,45, then a rejected 17th write of 99
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'(3 * i));
        step(0, 1, 0, 0, 8'd99);

        // 3: drain all 16, then clear the sticky errors
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 8'd0);
        step(0, 0, 0, 1, 8'd0);

        // 4: simultaneous read+write on a full FIFO, then drain
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'(3 * i));
        step(0, 1, 1, 0, 8'd7);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 8'd0);

        // 5: interleaved writes and reads across the pointer wrap, then drain
        for (int i = 0; i <= 45; i += 3) begin
            step(0, 1, 0, 0, 8'(i));
            if ((i % 2) == 0) step(0, 0, 1, 0, 8'd0);
        end
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 8'd0);

        // 6: reset with five words stored, then a read must underflow
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'(10 + i));
        step(1, 0, 0, 0, 8'd0);
        step(0, 0, 1, 0, 8'd0);
        step(0, 0, 0, 0, 8'd0);

        // Show-ahead instance
        sa_reset = 1'b0;
        sa_cycle(0, 0, 8'h00);
        chk("sa_reset_valid", 32'(sa_valid),    32'd0);
        chk("sa_reset_dout",  32'(sa_data_out), 32'd0);
        chk("sa_reset_empty", 32'(sa_empty),    32'd1);
        sa_cycle(1, 0, 8'hA5);
        chk("sa_head_dout",   32'(sa_data_out), 32'hA5);
        chk("sa_head_valid",  32'(sa_valid),    32'd1);
        sa_cycle(0, 0, 8'h00);
        chk("sa_hold_dout",   32'(sa_data_out), 32'hA5);
        chk("sa_hold_count",  32'(sa_count),    32'd1);
        sa_cycle(1, 0, 8'h3C);
        chk("sa_second_dout", 32'(sa_data_out), 32'hA5);
        chk("sa_second_cnt",  32'(sa_count),    32'd2);
        sa_cycle(0, 1, 8'h00);
        chk("sa_adv_dout",    32'(sa_data_out), 32'h3C);
        chk("sa_adv_valid",   32'(sa_valid),    32'd1);
        sa_cycle(0, 1, 8'h00);
        chk("sa_empty_valid", 32'(sa_valid),    32'd0);
        chk("sa_empty_flag",  32'(sa_empty),    32'd1);
        chk("sa_no_udf",      32'(sa_udf),      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
